// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
//   Shared definitions for the BCD down counter.
//   - bcd_digit_t : one 4-bit BCD digit
//   - BCD_MAX     : largest legal digit value (9)
//   - BCD_ZERO    : digit value zero
//   - bcd_dec()   : per-digit decrement, including recovery from illegal
//                   codes 10..15
// -----------------------------------------------------------------------------
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Decrement one digit. A zero digit takes the supplied wrap value, which is
  // either 9 or the reload digit. Illegal codes 10..15 always recover to 9.
  function automatic bcd_digit_t bcd_dec(input bcd_digit_t value,
                                         input bcd_digit_t wrap);
    bcd_digit_t result;
    if (value == BCD_ZERO) begin
      result = wrap;
    end else if (value > BCD_MAX) begin
      result = BCD_MAX;
    end else begin
      result = value - 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// -----------------------------------------------------------------------------
// bcd_down_digit
//   A single BCD digit register with asynchronous clear, synchronous load and
//   a step (decrement) enable.
//
//   Ports:
//     CLK        - rising-edge clock
//     CDN        - asynchronous active-low clear (digit goes to 0)
//     load       - synchronous load, wins over step
//     load_value - digit value loaded when load is high (unchecked)
//     step       - decrement this digit on the next edge
//     wrap_value - value taken when stepping from 0
//     digit      - registered digit value
//     is_zero    - digit equals 0 (illegal codes count as nonzero)
// -----------------------------------------------------------------------------
module bcd_down_digit
  import bcd_pkg::*;
(
  input  logic       CLK,
  input  logic       CDN,
  input  logic       load,
  input  bcd_digit_t load_value,
  input  logic       step,
  input  bcd_digit_t wrap_value,
  output bcd_digit_t digit,
  output logic       is_zero
);

  bcd_digit_t digit_reg;

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      digit_reg <= BCD_ZERO;
    end else if (load) begin
      digit_reg <= load_value;
    end else if (step) begin
      digit_reg <= bcd_dec(digit_reg, wrap_value);
    end
  end

  assign digit   = digit_reg;
  assign is_zero = (digit_reg == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// -----------------------------------------------------------------------------
// bcd_down_counter
//   Cascadable N-digit decade (BCD) down counter with parallel load, count
//   enable, terminal count and asynchronous active-low clear.
//
//   Build option: define BCD_DOWN_RELOAD_EN to add a reload register. The
//   register captures D on every load, and an enabled count from all-zero
//   then reloads it instead of wrapping to all-nines. Ports are identical in
//   both builds.
//
//   Parameters:
//     DIGITS - number of BCD digits, 1..8
//   Ports:
//     CLK  - rising-edge clock
//     CDN  - asynchronous active-low clear (Q and reload register go to 0)
//     LD   - synchronous parallel load, highest synchronous priority
//     EN   - count enable, decrement by one per clock
//     D    - load data, digit k in bits 4k+3..4k, digit 0 least significant
//     Q    - registered count, same packing as D
//     ZERO - Q is all zeros (combinational)
//     TC   - EN & ZERO (combinational), feeds EN of the next stage
// -----------------------------------------------------------------------------
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  CDN,
  input  logic                  LD,
  input  logic                  EN,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  ZERO,
  output logic                  TC
);

  logic [DIGITS-1:0]   is_zero;
  logic [DIGITS:0]     borrow;     // borrow[k]: digits 0..k-1 are all zero
  logic [DIGITS-1:0]   step;
  logic [4*DIGITS-1:0] all_nines;
  logic [4*DIGITS-1:0] wrap_bus;

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign borrow[gi+1]           = borrow[gi] & is_zero[gi];
      assign step[gi]               = EN & borrow[gi];
      assign all_nines[4*gi +: 4]   = BCD_MAX;

      bcd_down_digit u_digit (
        .CLK        (CLK),
        .CDN        (CDN),
        .load       (LD),
        .load_value (D[4*gi +: 4]),
        .step       (step[gi]),
        .wrap_value (wrap_bus[4*gi +: 4]),
        .digit      (Q[4*gi +: 4]),
        .is_zero    (is_zero[gi])
      );
    end
  endgenerate

  // The end of the borrow chain is exactly "every digit is zero".
  assign ZERO = borrow[DIGITS];
  assign TC   = EN & ZERO;

`ifdef BCD_DOWN_RELOAD_EN
  logic [4*DIGITS-1:0] reload_reg;

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      reload_reg <= '0;
    end else if (LD) begin
      reload_reg <= D;
    end
  end

  // Only a full-counter underflow reloads; a single digit borrowing out of 0
  // while higher digits are nonzero still goes to 9. When Q is all zero every
  // digit steps, so each digit picks up its own reload digit.
  assign wrap_bus = ZERO ? reload_reg : all_nines;
`else
  assign wrap_bus = all_nines;
`endif

endmodule

// File: tb/tb_bcd_down_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_down_counter
//   Bench for bcd_down_counter: a 2-digit instance, plus a cascade of two
//   1-digit instances (TC -> EN) alongside a 2-digit instance driven with the
//   same controls. Expected values come from a decimal-arithmetic reference
//   model. Honours BCD_DOWN_RELOAD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       cdn;
  logic       ld, en;
  logic [7:0] d;
  logic [7:0] q;
  logic       zero, tc;

  logic       c_ld, c_en;
  logic [3:0] c_dlo, c_dhi;
  logic [3:0] q_lo, q_hi;
  logic       z_lo, z_hi, tc_lo, tc_hi;
  logic [7:0] q_ref;
  logic       z_ref, tc_ref;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  logic [31:0] m_q, m_rl;         // main 2-digit
  logic [31:0] m_lo, m_rl_lo;     // cascade low stage
  logic [31:0] m_hi, m_rl_hi;     // cascade high stage
  logic [31:0] m_ref, m_rl_ref;   // 2-digit twin of the cascade

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2)) u_dut (
    .CLK(clk), .CDN(cdn), .LD(ld), .EN(en), .D(d),
    .Q(q), .ZERO(zero), .TC(tc)
  );

  bcd_down_counter #(.DIGITS(1)) u_lo (
    .CLK(clk), .CDN(cdn), .LD(c_ld), .EN(c_en), .D(c_dlo),
    .Q(q_lo), .ZERO(z_lo), .TC(tc_lo)
  );

  bcd_down_counter #(.DIGITS(1)) u_hi (
    .CLK(clk), .CDN(cdn), .LD(c_ld), .EN(tc_lo), .D(c_dhi),
    .Q(q_hi), .ZERO(z_hi), .TC(tc_hi)
  );

  bcd_down_counter #(.DIGITS(2)) u_ref (
    .CLK(clk), .CDN(cdn), .LD(c_ld), .EN(c_en), .D({c_dhi, c_dlo}),
    .Q(q_ref), .ZERO(z_ref), .TC(tc_ref)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int value, input int n);
    logic [31:0] r;
    int v;
    r = '0;
    v = value;
    for (int k = 0; k < n; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Value after one enabled count of an n-digit counter.
  // Legal contents: plain decimal subtraction with underflow to all-nines (or
  // the reload value). Illegal contents: walk the borrow rule digit by digit.
  function automatic logic [31:0] model_dec(input logic [31:0] cur, input int n,
                                            input logic [31:0] rl);
    logic [31:0] r;
    int  v, dig, top;
    bit  legal, borrow;
    legal = 1'b1;
    v     = 0;
    top   = 1;
    for (int k = n - 1; k >= 0; k--) begin
      dig = int'(cur[4*k +: 4]);
      if (dig > 9) legal = 1'b0;
      v   = v * 10 + dig;
      top = top * 10;
    end
    if (legal) begin
      if (v == 0) begin
`ifdef BCD_DOWN_RELOAD_EN
        r = rl;
`else
        r = to_bcd(top - 1, n);
`endif
      end else begin
        r = to_bcd(v - 1, n);
      end
    end else begin
      r      = cur;
      borrow = 1'b1;
      for (int k = 0; k < n; k++) begin
        dig = int'(cur[4*k +: 4]);
        if (borrow) r[4*k +: 4] = (dig == 0) ? 4'd9 : (dig > 9) ? 4'd9 : 4'(dig - 1);
        borrow = borrow && (dig == 0);
      end
    end
    return r;
  endfunction

  task automatic models_clear();
    m_q = '0;  m_rl = '0;
    m_lo = '0; m_rl_lo = '0;
    m_hi = '0; m_rl_hi = '0;
    m_ref = '0; m_rl_ref = '0;
  endtask

  task automatic check_outputs();
    check_eq("q", 32'(q), m_q);
    check_eq("zero", 32'(zero), 32'(m_q == 0));
    check_eq("tc", 32'(tc), 32'(en && (m_q == 0)));
    check_eq("casc_q", 32'({q_hi, q_lo}), {m_hi[3:0], m_lo[3:0]});
    check_eq("casc_tc", 32'(tc_hi), 32'(c_en && m_lo == 0 && m_hi == 0));
    check_eq("ref_q", 32'(q_ref), m_ref);
  endtask

  // One clock: advance the model on the edge, then compare #1 after it.
  task automatic step();
    logic en_hi;
    @(posedge clk);
    if (!cdn) begin
      models_clear();
    end else begin
      if (ld) begin
        m_q = 32'(d); m_rl = 32'(d);
      end else if (en) begin
        m_q = model_dec(m_q, 2, m_rl);
      end
      en_hi = c_en && (m_lo == 0);
      if (c_ld) begin
        m_lo = 32'(c_dlo); m_rl_lo = 32'(c_dlo);
        m_hi = 32'(c_dhi); m_rl_hi = 32'(c_dhi);
        m_ref = 32'({c_dhi, c_dlo}); m_rl_ref = m_ref;
      end else begin
        if (c_en)  m_lo  = model_dec(m_lo, 1, m_rl_lo);
        if (en_hi) m_hi  = model_dec(m_hi, 1, m_rl_hi);
        if (c_en)  m_ref = model_dec(m_ref, 2, m_rl_ref);
      end
    end
    #1;
    check_outputs();
    $display("step ld=%0b en=%0b d=%h q=%h tc=%0b | c_ld=%0b c_en=%0b casc=%h ref=%h",
             ld, en, d, q, tc, c_ld, c_en, {q_hi, q_lo}, q_ref);
  endtask

  // Asynchronous clear pulse placed between clock edges.
  task automatic clear_pulse();
    #2 cdn = 1'b0;
    #1;
    models_clear();
    check_eq("clr_q", 32'(q), 32'h0);
    check_eq("clr_zero", 32'(zero), 32'h1);
    check_eq("clr_tc", 32'(tc), 32'(en));
    check_eq("clr_casc", 32'({q_hi, q_lo}), 32'h0);
    $display("clear q=%h casc=%h ref=%h", q, {q_hi, q_lo}, q_ref);
    #1 cdn = 1'b1;
  endtask

  initial begin
    cdn = 1'b0; ld = 1'b0; en = 1'b0; d = 8'h00;
    c_ld = 1'b0; c_en = 1'b0; c_dlo = 4'h0; c_dhi = 4'h0;
    models_clear();

    // reset state with CDN held low across edges
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_q", 32'(q), 32'h0);
    check_eq("rst_zero", 32'(zero), 32'h1);
    check_eq("rst_tc", 32'(tc), 32'h0);
    en = 1'b1;
    #1;
    check_eq("rst_tc_en", 32'(tc), 32'h1);
    en = 1'b0;
    #1 cdn = 1'b1;

    // clear mid-count from 57, then count from zero after release
    ld = 1'b1; d = 8'h57;
    step();
    ld = 1'b0; en = 1'b1;
    clear_pulse();
    step();
    step();

    // load 21 and count all the way down, then one more (wrap)
    ld = 1'b1; en = 1'b0; d = 8'h21;
    step();
    ld = 1'b0; en = 1'b1;
    repeat (22) step();

    // load beats enable, then hold
    ld = 1'b1; en = 1'b1; d = 8'h40;
    step();
    ld = 1'b0; en = 1'b0;
    repeat (3) step();

    // illegal codes recover to 9
    ld = 1'b1; en = 1'b0; d = 8'h3C;
    step();
    ld = 1'b0; en = 1'b1;
    repeat (2) step();
    ld = 1'b1; en = 1'b0; d = 8'hF0;
    step();
    ld = 1'b0; en = 1'b1;
    repeat (2) step();

    // periodic count from 03 (reload build repeats, default build wraps)
    ld = 1'b1; en = 1'b0; d = 8'h03;
    step();
    ld = 1'b0; en = 1'b1;
    repeat (9) step();

    // cascade loaded hi=1 lo=0 vs 2-digit twin loaded 10
    c_ld = 1'b1; c_en = 1'b0; c_dhi = 4'h1; c_dlo = 4'h0;
    step();
    c_ld = 1'b0; c_en = 1'b1;
    repeat (24) step();

    // random traffic on both counters, occasional clears
    repeat (400) begin
      ld    = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      d     = 8'($urandom);
      c_ld  = ($urandom_range(0, 11) == 0);
      c_en  = ($urandom_range(0, 3) != 0);
      c_dlo = 4'($urandom_range(0, 9));
      c_dhi = 4'($urandom_range(0, 9));
      step();
      if ($urandom_range(0, 59) == 0) clear_pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
